// File: rtl/regfile_alu_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_alu_unit_pkg
//  Description : Shared widths and op-bit indices for the regfile/ALU slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_alu_unit_pkg;

   localparam int c_XLEN   = 32;
   localparam int c_NREGS  = 32;
   localparam int c_REG_AW = 5;
   localparam int c_OP_W   = 9;

   // Bit positions inside the one-hot alu_op vector
   localparam int c_OP_AUIPC = 0;
   localparam int c_OP_LUI   = 1;
   localparam int c_OP_JAL   = 2;
   localparam int c_OP_JALR  = 3;
   localparam int c_OP_ADDI  = 4;
   localparam int c_OP_ADD   = 5;
   localparam int c_OP_LW    = 6;
   localparam int c_OP_LBU   = 7;
   localparam int c_OP_SW    = 8;

   typedef logic [c_XLEN-1:0] word_t;
   typedef logic [c_OP_W-1:0] op_vec_t;

   function automatic logic f_is_onehot(input op_vec_t v);
      return (v != '0) && ((v & (v - op_vec_t'(1))) == '0);
   endfunction

endpackage : regfile_alu_unit_pkg
`default_nettype wire

// File: rtl/regfile_alu_unit_funct3_dec.sv
`default_nettype none
// ============================================================================
//  Module      : funct3_dec
//  Description : 3-to-8 one-hot decoder for the instruction funct3 field.
//  Revision    : 1.0 - initial release
// ============================================================================
module funct3_dec (
   input  logic [2:0] i_funct3,
   output logic [7:0] o_hot
);

   for (genvar g = 0; g < 8; g++) begin : g_hot_bit
      assign o_hot[g] = (i_funct3 == 3'(g));
   end

endmodule : funct3_dec
`default_nettype wire

// File: rtl/regfile_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_alu_unit
//  Description : 32x32 register file with combinational reads, a one-hot
//                ALU result mux feeding the write port, and funct3 decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_alu_unit
   import regfile_alu_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wen,
   input  logic [4:0]  waddr,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   input  logic [8:0]  alu_op,
   input  logic [31:0] imm,
   input  logic [31:0] pc,
   input  logic [31:0] mem_rdata,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   output logic [31:0] result,
   output logic [7:0]  hot_funct3
);

   word_t r_regs [c_NREGS];
   word_t w_src1;
   word_t w_src2;
   word_t w_result;
   logic  w_wr_fire;

   // Index 0 is masked on read so it stays zero regardless of array content
   assign w_src1 = (raddr1 == '0) ? '0 : r_regs[raddr1];
   assign w_src2 = (raddr2 == '0) ? '0 : r_regs[raddr2];

   assign w_wr_fire = wen && (waddr != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < c_NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_fire) begin
         r_regs[waddr] <= w_result;
      end
   end

   // Illegal op vectors (none or several bits) collapse to zero
   always_comb begin
      w_result = '0;
      if (f_is_onehot(alu_op)) begin
         case (1'b1)
            alu_op[c_OP_AUIPC]: w_result = pc + imm;
            alu_op[c_OP_LUI]:   w_result = imm;
            alu_op[c_OP_JAL]:   w_result = pc + word_t'(4);
            alu_op[c_OP_JALR]:  w_result = pc + word_t'(4);
            alu_op[c_OP_ADDI]:  w_result = w_src1 + imm;
            alu_op[c_OP_ADD]:   w_result = w_src1 + w_src2;
            alu_op[c_OP_LW]:    w_result = mem_rdata;
            alu_op[c_OP_LBU]:   w_result = {24'b0, mem_rdata[7:0]};
            alu_op[c_OP_SW]:    w_result = w_src2;
            default:            w_result = '0;
         endcase
      end
   end

   funct3_dec u_funct3_dec (
      .i_funct3 (funct3),
      .o_hot    (hot_funct3)
   );

   assign rdata1 = w_src1;
   assign rdata2 = w_src2;
   assign result = w_result;

endmodule : regfile_alu_unit
`default_nettype wire

// File: tb/tb_regfile_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_alu_unit
//  Description : Self-checking bench for regfile_alu_unit with a behavioural
//                register/ALU model and directed plus random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_alu_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wen = 1'b0;
   logic [4:0]  waddr = '0;
   logic [4:0]  raddr1 = '0;
   logic [4:0]  raddr2 = '0;
   logic [8:0]  alu_op = '0;
   logic [31:0] imm = '0;
   logic [31:0] pc = '0;
   logic [31:0] mem_rdata = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic [31:0] result;
   logic [7:0]  hot_funct3;

   int n_pass = 0;
   int n_total = 0;

   logic [31:0] m_regs [32];

   regfile_alu_unit dut (
      .clk        (clk),
      .reset      (reset),
      .wen        (wen),
      .waddr      (waddr),
      .raddr1     (raddr1),
      .raddr2     (raddr2),
      .alu_op     (alu_op),
      .imm        (imm),
      .pc         (pc),
      .mem_rdata  (mem_rdata),
      .funct3     (funct3),
      .rdata1     (rdata1),
      .rdata2     (rdata2),
      .result     (result),
      .hot_funct3 (hot_funct3)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      return (a == 0) ? 32'h0 : m_regs[a];
   endfunction

   function automatic logic [31:0] model_result();
      logic [31:0] s1 = model_read(raddr1);
      logic [31:0] s2 = model_read(raddr2);
      if ($countones(alu_op) != 1) return 32'h0;
      if (alu_op[0]) return pc + imm;
      if (alu_op[1]) return imm;
      if (alu_op[2] || alu_op[3]) return pc + 32'd4;
      if (alu_op[4]) return s1 + imm;
      if (alu_op[5]) return s1 + s2;
      if (alu_op[6]) return mem_rdata;
      if (alu_op[7]) return {24'h0, mem_rdata[7:0]};
      return s2;
   endfunction

   // Model state: async clear on reset, write on rising edge
   always @(negedge reset) for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
   always @(posedge clk) if (reset && wen && waddr != 0) m_regs[waddr] = model_result();

   // Mid-cycle comparison of every output against the model
   always @(negedge clk) begin
      check("cmp_rdata1", rdata1, model_read(raddr1));
      check("cmp_rdata2", rdata2, model_read(raddr2));
      check("cmp_result", result, model_result());
      check("cmp_hot_funct3", {24'h0, hot_funct3}, 32'h1 << funct3);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      // Reset read-back of every index
      #2;
      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i);
         raddr2 = 5'(31 - i);
         #1;
         check("reset_rdata1", rdata1, 32'h0);
         check("reset_rdata2", rdata2, 32'h0);
      end
      @(negedge clk);
      #2 reset = 1'b1;
      tick();

      // addi then add
      alu_op = 9'h010; raddr1 = 0; imm = 32'h5; wen = 1; waddr = 3;
      #1 check("addi_result", result, 32'h5);
      tick();
      alu_op = 9'h020; raddr1 = 3; raddr2 = 3; waddr = 4;
      #1 check("reg3_after_addi", rdata1, 32'h5);
      check("add_result", result, 32'hA);
      tick();
      raddr1 = 4; wen = 0;
      #1 check("reg4_after_add", rdata1, 32'hA);
      check("model_reg4", m_regs[4], 32'hA);

      // write to x0 is ignored; lbu zero-extends
      alu_op = 9'h002; imm = 32'hDEADBEEF; wen = 1; waddr = 0;
      tick();
      wen = 0; raddr1 = 0;
      #1 check("x0_reads_zero", rdata1, 32'h0);
      alu_op = 9'h080; mem_rdata = 32'h123456F0;
      #1 check("lbu_result", result, 32'h000000F0);
      alu_op = 9'h040;
      #1 check("lw_result", result, 32'h123456F0);

      // pc-relative ops and wrap-around
      pc = 32'h80000000; imm = 32'h00001000;
      alu_op = 9'h001; #1 check("auipc_result", result, 32'h80001000);
      alu_op = 9'h004; #1 check("jal_result", result, 32'h80000004);
      alu_op = 9'h008; #1 check("jalr_result", result, 32'h80000004);
      alu_op = 9'h002; #1 check("lui_result", result, 32'h00001000);
      imm = 32'hFFFFFFFF; wen = 1; waddr = 7;
      tick();
      alu_op = 9'h010; raddr1 = 7; imm = 32'h1; wen = 0;
      #1 check("addi_wrap", result, 32'h0);
      alu_op = 9'h100; raddr2 = 7;
      #1 check("sw_result", result, 32'hFFFFFFFF);

      // no bypass on same-cycle read, then async reset clears at once
      alu_op = 9'h002; imm = 32'h55; wen = 1; waddr = 5; raddr1 = 5;
      #1 check("reg5_old_before_edge", rdata1, 32'h0);
      tick();
      check("reg5_new_after_edge", rdata1, 32'h55);
      imm = 32'h77;
      #1 reset = 1'b0;
      #1 check("reg5_cleared_by_reset", rdata1, 32'h0);
      tick();
      check("reset_blocks_write", rdata1, 32'h0);
      #1 reset = 1'b1;
      #1 check("still_zero_before_edge", rdata1, 32'h0);
      tick();
      check("first_write_after_reset", rdata1, 32'h77);
      wen = 0;

      // funct3 sweep and illegal op vector
      for (int f = 0; f < 8; f++) begin
         funct3 = 3'(f);
         #1 check("hot_funct3", {24'h0, hot_funct3}, 32'h1 << f);
      end
      alu_op = 9'h003;
      #1 check("multi_hot_op_zero", result, 32'h0);
      alu_op = 9'h000;
      #1 check("zero_op_zero", result, 32'h0);

      // randomized phase
      for (int n = 0; n < 400; n++) begin
         tick();
         wen       = 1'($urandom_range(0, 1));
         waddr     = 5'($urandom);
         raddr1    = 5'($urandom);
         raddr2    = 5'($urandom);
         imm       = $urandom;
         pc        = $urandom;
         mem_rdata = $urandom;
         funct3    = 3'($urandom);
         if ($urandom_range(0, 4) == 0) alu_op = 9'($urandom);
         else alu_op = 9'h1 << $urandom_range(0, 8);
         if (n == 200) begin
            #1 reset = 1'b0;
            @(negedge clk);
            #2 reset = 1'b1;
         end
      end
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_regfile_alu_unit
`default_nettype wire
